lvds_frame_rx: RTL and testbench

- Receive-side counterpart of the DAC transmit link: captures the parallel sample bus (`rx_data`) and its frame strobe (`rx_strobe`).
- Both are already converted to single-ended by the IBUFDS stage, and the block runs on the recovered link clock.
- Locks to the strobe cadence and outputs whole frames on an AXI-Stream master, through an internal first-word-fall-through (FWFT) FIFO.
- Reports lock status, error counts and dropped-frame counts to the status register block.

---
 rtl/lvds_frame_rx.sv | 194 +++++++++++++++++++
 tb/tb_lvds_frame_rx.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_frame_rx.sv
// LVDS frame receiver: locks onto the frame-strobe cadence and streams whole frames out over AXI-Stream via an FWFT FIFO.
// Optional feature macro RX_TWOS_COMP_EN: invert the sample MSB (offset-binary -> two's complement) on the way into the FIFO.
module lvds_frame_rx #(
  parameter int DATA_W     = 12,
  parameter int FRAME_LEN  = 16,
  parameter int LOCK_CNT   = 3,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_strobe,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              locked,
  output logic [15:0]       err_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int BEAT_W  = $clog2(FRAME_LEN);
  localparam int GOOD_W  = $clog2(LOCK_CNT + 1);
  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int PTR_W   = ADDR_W + 1;
  localparam int ENTRY_W = DATA_W + 2;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_SYNC   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                strobe_q, strobe_d;
  logic [BEAT_W-1:0]   beat_q, beat_d, beat_next;
  logic [GOOD_W-1:0]   good_q, good_d, good_inc;
  logic                accept_q, accept_d;
  logic [15:0]         err_q, err_d;
  logic [15:0]         drop_q, drop_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];

  logic                frame_start, err_inc, drop_inc;
  logic                push, push_last, push_user, wr_en, pop;
  logic [DATA_W-1:0]   sample;
  logic [PTR_W-1:0]    fifo_cnt, fifo_free;
  logic                fifo_empty, fifo_full;
  logic [ENTRY_W-1:0]  rd_word;

  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_free  = PTR_W'(FIFO_DEPTH) - fifo_cnt;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = fifo_cnt[ADDR_W];
  assign beat_next  = (beat_q == BEAT_W'(FRAME_LEN - 1)) ? '0 : beat_q + 1'b1;
  assign good_inc   = good_q + 1'b1;

`ifdef RX_TWOS_COMP_EN
  assign sample = {~data_q[DATA_W-1], data_q[DATA_W-2:0]};
`else
  assign sample = data_q;
`endif

  always_comb begin
    // NOTE: every variable gets its default before the case so no path can infer a latch.
    data_d      = rx_data;
    strobe_d    = rx_strobe;
    state_d     = state_q;
    beat_d      = beat_q;
    good_d      = good_q;
    accept_d    = accept_q;
    frame_start = 1'b0;
    err_inc     = 1'b0;
    drop_inc    = 1'b0;
    push        = 1'b0;
    push_last   = 1'b0;
    push_user   = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (strobe_q) begin
          state_d = ST_VERIFY;
          beat_d  = BEAT_W'(1);
          good_d  = GOOD_W'(1);
        end
      end
      ST_VERIFY: begin
        beat_d = beat_next;
        if (beat_q == '0) begin
          if (!strobe_q) begin
            state_d = ST_HUNT;
          end else begin
            good_d = good_inc;
            if (good_inc == GOOD_W'(LOCK_CNT)) begin
              state_d     = ST_SYNC;
              frame_start = 1'b1;
            end
          end
        end else if (strobe_q) begin
          beat_d = BEAT_W'(1);
          good_d = GOOD_W'(1);
        end
      end
      ST_SYNC: begin
        beat_d = beat_next;
        if (beat_q == '0) begin
          if (strobe_q) begin
            frame_start = 1'b1;
          end else begin
            err_inc = 1'b1;
            state_d = ST_HUNT;
          end
        end else if (strobe_q) begin
          // Misplaced strobe truncates the current frame and restarts verification from here.
          push      = accept_q;
          push_last = 1'b1;
          push_user = 1'b1;
          err_inc   = 1'b1;
          state_d   = ST_VERIFY;
          beat_d    = BEAT_W'(1);
          good_d    = GOOD_W'(1);
        end else begin
          push      = accept_q;
          push_last = (beat_q == BEAT_W'(FRAME_LEN - 1));
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Whole-frame admission: a frame enters only if all of it is guaranteed to fit.
    if (frame_start) begin
      if (fifo_free >= PTR_W'(FRAME_LEN)) begin
        accept_d = 1'b1;
        push     = 1'b1;
      end else begin
        accept_d = 1'b0;
        drop_inc = 1'b1;
      end
    end

    err_d  = (err_inc  && err_q  != 16'hFFFF) ? err_q  + 16'd1 : err_q;
    drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

    pop      = !fifo_empty && m_axis_tready;
    wr_en    = push && (!fifo_full || pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_HUNT;
      data_q   <= '0;
      strobe_q <= 1'b0;
      beat_q   <= '0;
      good_q   <= '0;
      accept_q <= 1'b0;
      err_q    <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      beat_q   <= beat_d;
      good_q   <= good_d;
      accept_q <= accept_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define what is valid, and outputs are gated while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {push_user, push_last, sample};
  end

  assign rd_word       = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : rd_word[DATA_W-1:0];
  assign m_axis_tlast  = fifo_empty ? 1'b0 : rd_word[DATA_W];
  assign m_axis_tuser  = fifo_empty ? 1'b0 : rd_word[DATA_W+1];
  assign locked        = (state_q == ST_SYNC);
  assign err_cnt       = err_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_lvds_frame_rx.sv
// Self-checking bench for lvds_frame_rx: directed scenarios plus random traffic against a frame-level reference model.
module tb_lvds_frame_rx;

  localparam int DW = 12;
  localparam int FL = 16;
  localparam int LC = 3;
  localparam int FD = 32;
  localparam int VW = 3 + DW + 1 + 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] rx_data;
  logic          rx_strobe;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          locked;
  logic [15:0]   err_cnt;
  logic [15:0]   drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lvds_frame_rx #(.DATA_W(DW), .FRAME_LEN(FL), .LOCK_CNT(LC), .FIFO_DEPTH(FD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_strobe     (rx_strobe),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .locked        (locked),
    .err_cnt       (err_cnt),
    .drop_cnt      (drop_cnt)
  );

  logic [VW-1:0] dut_v;
  assign dut_v = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, locked, err_cnt, drop_cnt};

  // Reference model: frames are tracked by position since the last anchoring strobe.
  typedef struct packed {
    logic          user;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         mq[$];
  logic          r_strb;
  logic [DW-1:0] r_data;
  bit            anchored, synced, taking;
  int            pos, streak, m_err, m_drop;

  function automatic logic [DW-1:0] conv(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
`ifdef RX_TWOS_COMP_EN
    r[DW-1] = ~r[DW-1];
`endif
    return r;
  endfunction

  function automatic logic [VW-1:0] exp_v();
    beat_t h;
    h = '0;
    if (mq.size() != 0) h = mq[0];
    return {mq.size() != 0, h.user, h.last, h.data, synced, m_err[15:0], m_drop[15:0]};
  endfunction

  task automatic model_edge(input logic [DW-1:0] d, input logic s, input logic rdy, input logic rst);
    int    pre;
    bit    do_pop, do_push, new_frame;
    beat_t e;
    if (!rst) begin
      mq.delete();
      r_strb = 1'b0; r_data = '0;
      anchored = 0; synced = 0; taking = 0;
      pos = 0; streak = 0; m_err = 0; m_drop = 0;
      return;
    end
    pre       = mq.size();
    do_pop    = (pre > 0) && rdy;
    do_push   = 0;
    new_frame = 0;
    e         = '0;
    e.data    = conv(r_data);
    if (anchored) pos = (pos + 1) % FL;
    if (!anchored) begin
      if (r_strb) begin anchored = 1; synced = 0; pos = 0; streak = 1; end
    end else if (!synced) begin
      if (pos == 0) begin
        if (r_strb) begin
          streak++;
          if (streak >= LC) begin synced = 1; new_frame = 1; end
        end else anchored = 0;
      end else if (r_strb) begin
        pos = 0; streak = 1;
      end
    end else begin
      if (pos == 0) begin
        if (r_strb) new_frame = 1;
        else begin
          anchored = 0; synced = 0;
          if (m_err < 65535) m_err++;
        end
      end else if (r_strb) begin
        if (taking) begin do_push = 1; e.last = 1; e.user = 1; end
        if (m_err < 65535) m_err++;
        synced = 0; pos = 0; streak = 1;
      end else if (taking) begin
        do_push = 1;
        e.last  = (pos == FL - 1);
      end
    end
    if (new_frame) begin
      if (FD - pre >= FL) begin taking = 1; do_push = 1; end
      else begin
        taking = 0;
        if (m_drop < 65535) m_drop++;
      end
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(e);
    r_strb = s;
    r_data = d;
  endtask

  task automatic tick(input logic [DW-1:0] d, input logic s, input logic rdy);
    rx_data       = d;
    rx_strobe     = s;
    m_axis_tready = rdy;
    @(posedge clk);
    model_edge(d, s, rdy, rst_n);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) tick(DW'($urandom), 1'b1, 1'b1);
    vectors++;
    if (m_axis_tvalid !== 1'b0 || locked !== 1'b0 || err_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: tvalid=%b locked=%b err=%0d drop=%0d, all required 0", m_axis_tvalid, locked, err_cnt, drop_cnt);
    end
    vectors++;
    if (dut_v !== exp_v()) begin
      miscompares++;
      $display("FAIL reset_vector: dut=%h model=%h", dut_v, exp_v());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock_acquisition();
    int lock_i = -1, first_i = -1, beats = 0;
    logic [DW-1:0] first_d = '0;
    bit done = 0, last_user = 1;
    for (int i = 0; i < 96; i++) begin
      tick(DW'(i), (i % FL) == 0, 1'b1);
      vectors++;
      if (dut_v !== exp_v()) begin
        miscompares++;
        $display("FAIL lock cycle %0d: dut=%h model=%h", i, dut_v, exp_v());
      end
      if (locked === 1'b1 && lock_i < 0) lock_i = i;
      if (m_axis_tvalid === 1'b1 && first_i < 0) begin first_i = i; first_d = m_axis_tdata; end
      if (first_i >= 0 && !done && m_axis_tvalid === 1'b1) begin
        beats++;
        if (m_axis_tlast === 1'b1) begin done = 1; last_user = m_axis_tuser; end
      end
    end
    vectors++;
    if (lock_i !== 33) begin miscompares++; $display("FAIL lock_rise: tick %0d, required 33", lock_i); end
    vectors++;
    if (first_i + 1 - 32 !== 2) begin miscompares++; $display("FAIL lock_latency: %0d cycles, required 2", first_i + 1 - 32); end
    vectors++;
    if (first_d !== conv(12'h020)) begin miscompares++; $display("FAIL lock_first_data: %h, required %h", first_d, conv(12'h020)); end
    vectors++;
    if (beats !== FL || last_user !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_frame_len: %0d beats tuser=%b, required 16 beats tuser=0", beats, last_user);
    end
  endtask

  task automatic test_backpressure_drop();
    logic bl_last[48];
    logic bl_user[48];
    int nb = 0;
    logic rdy;
    for (int i = 0; i < 96; i++) begin
      rdy = (i < 2) || (i >= 34);
      if (i >= 34 && m_axis_tvalid === 1'b1 && nb < 48) begin
        bl_last[nb] = m_axis_tlast; bl_user[nb] = m_axis_tuser; nb++;
      end
      tick(DW'($urandom), (i % FL) == 0, rdy);
      vectors++;
      if (dut_v !== exp_v()) begin
        miscompares++;
        $display("FAIL backpressure cycle %0d: dut=%h model=%h", i, dut_v, exp_v());
      end
      if (i == 32 || i == 33) begin
        vectors++;
        if (drop_cnt !== ((i == 33) ? 16'd1 : 16'd0)) begin
          miscompares++;
          $display("FAIL drop_count tick %0d: %0d, required %0d", i, drop_cnt, (i == 33) ? 1 : 0);
        end
      end
    end
    vectors++;
    if (nb !== 48) begin miscompares++; $display("FAIL drain_beats: %0d, required 48", nb); end
    for (int k = 0; k < nb; k++) begin
      vectors++;
      if (bl_last[k] !== ((k % FL) == FL - 1) || bl_user[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL drain_beat %0d: tlast=%b tuser=%b, required tlast=%b tuser=0", k, bl_last[k], bl_user[k], (k % FL) == FL - 1);
      end
    end
  endtask

  task automatic test_misplaced_strobe();
    logic [DW-1:0] d, d21 = '0, got_d = '0;
    logic s, got_last = 1'b0;
    bit found = 0;
    for (int i = 0; i < 85; i++) begin
      d = DW'($urandom);
      if (i == 21) d21 = d;
      s = (i < 21) ? ((i % FL) == 0) : (((i - 21) % FL) == 0);
      tick(d, s, 1'b1);
      vectors++;
      if (dut_v !== exp_v()) begin
        miscompares++;
        $display("FAIL misplaced cycle %0d: dut=%h model=%h", i, dut_v, exp_v());
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tuser === 1'b1 && !found) begin
        found = 1; got_d = m_axis_tdata; got_last = m_axis_tlast;
      end
      if (i == 22) begin
        vectors++;
        if (err_cnt !== 16'd1 || locked !== 1'b0) begin
          miscompares++;
          $display("FAIL misplaced_err: err=%0d locked=%b, required err=1 locked=0", err_cnt, locked);
        end
      end
      if (i == 53 || i == 54) begin
        vectors++;
        if (locked !== (i == 54)) begin
          miscompares++;
          $display("FAIL misplaced_relock tick %0d: locked=%b, required %b", i, locked, i == 54);
        end
      end
    end
    vectors++;
    if (!found || got_d !== conv(d21) || got_last !== 1'b1) begin
      miscompares++;
      $display("FAIL truncated_beat: seen=%0d data=%h tlast=%b, required data=%h tlast=1", found, got_d, got_last, conv(d21));
    end
  endtask

  task automatic test_missing_strobe();
    logic [15:0] err0;
    logic rdy;
    err0 = 16'(m_err);
    for (int i = 0; i < 96; i++) begin
      rdy = (i < 32) ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(DW'($urandom), (i % FL) == 0 && i != 32, rdy);
      vectors++;
      if (dut_v !== exp_v()) begin
        miscompares++;
        $display("FAIL missing cycle %0d: dut=%h model=%h", i, dut_v, exp_v());
      end
      if (i == 33) begin
        vectors++;
        if (err_cnt !== err0 + 16'd1 || locked !== 1'b0) begin
          miscompares++;
          $display("FAIL missing_err: err=%0d locked=%b, required err=%0d locked=0", err_cnt, locked, err0 + 16'd1);
        end
      end
      if (i == 80 || i == 81) begin
        vectors++;
        if (locked !== (i == 81) || m_axis_tvalid !== (i == 81)) begin
          miscompares++;
          $display("FAIL missing_relock tick %0d: locked=%b tvalid=%b, required %b", i, locked, m_axis_tvalid, i == 81);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 41; i++) begin
      rst_n = (i != 23);
      tick(DW'($urandom), (i % FL) == 0, i < 4);
      vectors++;
      if (dut_v !== exp_v()) begin
        miscompares++;
        $display("FAIL reset_mid cycle %0d: dut=%h model=%h", i, dut_v, exp_v());
      end
      if (i == 23) begin
        vectors++;
        if (m_axis_tvalid !== 1'b0 || locked !== 1'b0 || err_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
          miscompares++;
          $display("FAIL reset_mid_state: tvalid=%b locked=%b err=%0d drop=%0d, all required 0", m_axis_tvalid, locked, err_cnt, drop_cnt);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_format();
    logic [DW-1:0] want;
`ifdef RX_TWOS_COMP_EN
    want = 12'h000;
`else
    want = 12'h800;
`endif
    for (int i = 0; i < 64; i++) begin
      tick((i == 32) ? 12'h800 : DW'($urandom), (i % FL) == 0, 1'b1);
      vectors++;
      if (dut_v !== exp_v()) begin
        miscompares++;
        $display("FAIL format cycle %0d: dut=%h model=%h", i, dut_v, exp_v());
      end
      if (i == 33) begin
        vectors++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== want) begin
          miscompares++;
          $display("FAIL format_msb: tvalid=%b data=%h, required 1/%h", m_axis_tvalid, m_axis_tdata, want);
        end
      end
    end
  endtask

  task automatic test_random();
    int ph = 0, r;
    logic s;
    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 99);
      s = (ph % FL) == 0;
      if (s && r < 3) s = 1'b0;
      else if (!s && r < 2) begin s = 1'b1; ph = 0; end
      tick(DW'($urandom), s, $urandom_range(0, 3) != 0);
      ph++;
      vectors++;
      if (dut_v !== exp_v()) begin
        miscompares++;
        $display("FAIL random cycle %0d: dut=%h model=%h", i, dut_v, exp_v());
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    rx_data       = '0;
    rx_strobe     = 1'b0;
    m_axis_tready = 1'b0;
    test_reset();
    test_lock_acquisition();
    test_backpressure_drop();
    test_misplaced_strobe();
    test_missing_strobe();
    test_reset_mid_frame();
    test_format();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
